// File: rtl/parser_result_fifo_pkg.sv
// Shared parser result format: default field geometry and the per-packet record
// layout used by the parser, this FIFO and downstream consumers.
package parser_pkg;

    localparam int FIELD_NUMBER_DEF   = 4;
    localparam int FIELD_SIZE_MAX_DEF = 4;
    localparam int SEQ_W_DEF          = 8;

    localparam int FIELD_VEC_W = FIELD_NUMBER_DEF * FIELD_SIZE_MAX_DEF * 8;
    localparam int REC_W       = SEQ_W_DEF + 2 * FIELD_NUMBER_DEF + FIELD_VEC_W;

    typedef struct packed {
        logic [SEQ_W_DEF-1:0]        seq;
        logic [FIELD_NUMBER_DEF-1:0] error;
        logic [FIELD_NUMBER_DEF-1:0] valid;
        logic [FIELD_VEC_W-1:0]      field;
    } parser_rec_t;

endpackage

// File: rtl/parser_result_fifo_if.sv
// Parser result input and buffered record output of parser_result_fifo.
// The slave side is the FIFO; the master side is the parser/consumer environment.
interface parser_result_fifo_if
    import parser_pkg::*;
#(
    parameter int FIELD_NUMBER   = FIELD_NUMBER_DEF,
    parameter int FIELD_SIZE_MAX = FIELD_SIZE_MAX_DEF,
    parameter int SEQ_W          = SEQ_W_DEF
);
    localparam int VEC_W = FIELD_NUMBER * FIELD_SIZE_MAX * 8;

    logic                    InRes_Ready;
    logic [VEC_W-1:0]        InRes_Field;
    logic [FIELD_NUMBER-1:0] InRes_Valid;
    logic [FIELD_NUMBER-1:0] InRes_Error;

    logic                    OutRec_Valid;
    logic                    OutRec_Ready;
    logic [VEC_W-1:0]        OutRec_Field;
    logic [FIELD_NUMBER-1:0] OutRec_FieldValid;
    logic [FIELD_NUMBER-1:0] OutRec_Error;
    logic                    OutRec_Good;
    logic [SEQ_W-1:0]        OutRec_Seq;

    modport slave (
        input  InRes_Ready, InRes_Field, InRes_Valid, InRes_Error, OutRec_Ready,
        output OutRec_Valid, OutRec_Field, OutRec_FieldValid, OutRec_Error,
               OutRec_Good, OutRec_Seq
    );

    modport master (
        output InRes_Ready, InRes_Field, InRes_Valid, InRes_Error, OutRec_Ready,
        input  OutRec_Valid, OutRec_Field, OutRec_FieldValid, OutRec_Error,
               OutRec_Good, OutRec_Seq
    );

endinterface

// File: rtl/parser_result_fifo_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment restarts the count at 1 so that event is not lost.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = WIDTH'(inc_i);
        end else if (inc_i && !(&count_q)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/parser_result_fifo.sv
// Buffers per-packet parser results tagged with a sequence number and hands them
// to the consumer over valid/ready; results arriving while full are counted and dropped.
module parser_result_fifo
    import parser_pkg::*;
#(
    parameter int FIELD_NUMBER   = FIELD_NUMBER_DEF,
    parameter int FIELD_SIZE_MAX = FIELD_SIZE_MAX_DEF,
    parameter int DEPTH          = 8,
    parameter int SEQ_W          = SEQ_W_DEF,
    parameter int DROP_W         = 16
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     Clr,
    parser_result_fifo_if.slave      Bus,
    output logic [$clog2(DEPTH):0]   Fill,
    output logic                     Overflow,
    output logic [DROP_W-1:0]        DropCnt
);

    localparam int VEC_W  = FIELD_NUMBER * FIELD_SIZE_MAX * 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;

    typedef struct packed {
        logic [SEQ_W-1:0]        seq;
        logic [FIELD_NUMBER-1:0] error;
        logic [FIELD_NUMBER-1:0] valid;
        logic [VEC_W-1:0]        field;
    } rec_t;

    rec_t              mem_q [DEPTH];
    rec_t              inRec;
    rec_t              head_q, head_d;
    logic              headValid_q, headValid_d;
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic              overflow_q, overflow_d;
    logic              full, pop, push, drop;

    always_comb begin
        inRec       = '0;
        inRec.seq   = seq_q;
        inRec.error = Bus.InRes_Error;
        inRec.valid = Bus.InRes_Valid;
        inRec.field = Bus.InRes_Field;
    end

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign full = (fill_q == FILL_W'(DEPTH));
    assign pop  = headValid_q & Bus.OutRec_Ready;
    assign push = Bus.InRes_Ready & (~full | pop);
    assign drop = Bus.InRes_Ready & full & ~pop;

    // The output register mirrors the head slot; a record arriving when it will be
    // the only one held bypasses memory so it is presented one edge after capture.
    always_comb begin
        wrPtr_d     = wrPtr_q + PTR_W'(push);
        rdPtr_d     = rdPtr_q + PTR_W'(pop);
        fill_d      = fill_q + FILL_W'(push) - FILL_W'(pop);
        seq_d       = seq_q + SEQ_W'(Bus.InRes_Ready);
        overflow_d  = drop ? 1'b1 : (Clr ? 1'b0 : overflow_q);
        headValid_d = (fill_d != '0);
        head_d      = '0;
        if (push && fill_d == FILL_W'(1)) begin
            head_d = inRec;
        end else if (fill_d != '0) begin
            head_d = mem_q[rdPtr_d];
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= inRec;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fill_q      <= '0;
            seq_q       <= '0;
            overflow_q  <= 1'b0;
            headValid_q <= 1'b0;
            head_q      <= '0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            fill_q      <= fill_d;
            seq_q       <= seq_d;
            overflow_q  <= overflow_d;
            headValid_q <= headValid_d;
            head_q      <= head_d;
        end
    end

    sat_counter #(
        .WIDTH (DROP_W)
    ) u_dropCnt (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .inc_i   (drop),
        .clr_i   (Clr),
        .count_o (DropCnt)
    );

    assign Bus.OutRec_Valid      = headValid_q;
    assign Bus.OutRec_Field      = head_q.field;
    assign Bus.OutRec_FieldValid = head_q.valid;
    assign Bus.OutRec_Error      = head_q.error;
    assign Bus.OutRec_Seq        = head_q.seq;
    assign Bus.OutRec_Good       = headValid_q & (&head_q.valid) & ~(|head_q.error);

    assign Fill     = fill_q;
    assign Overflow = overflow_q;

endmodule

// File: tb/tb_parser_result_fifo.sv
// Self-checking bench for parser_result_fifo: directed vector table, hand-written
// corner sequences and randomized traffic checked against a queue-based model.
module tb_parser_result_fifo;
    import parser_pkg::*;

    localparam int DEPTH  = 8;
    localparam int DROP_W = 4;
    localparam int VW     = FIELD_VEC_W;

    logic              Clk = 1'b0;
    logic              Rst_n = 1'b0;
    logic              Clr = 1'b0;
    logic [3:0]        Fill;
    logic              Overflow;
    logic [DROP_W-1:0] DropCnt;

    parser_result_fifo_if bus ();

    parser_result_fifo #(
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Clr      (Clr),
        .Bus      (bus),
        .Fill     (Fill),
        .Overflow (Overflow),
        .DropCnt  (DropCnt)
    );

    always #5 Clk = ~Clk;

    parser_rec_t modelQ[$];
    logic [7:0]  modelSeq;
    int          modelDrops;
    logic        modelOvf;
    int          checks;
    int          passes;

    typedef struct {
        logic          inRdy;
        logic [VW-1:0] field;
        logic          outRdy;
        logic          expValid;
        logic [7:0]    expSeq;
        logic [VW-1:0] expField;
        logic [3:0]    expFill;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Queue model: the consumer sees the head whenever anything is held; a result is
    // lost only when capacity is reached and nothing leaves on the same edge.
    task automatic modelStep(input logic inRdy, input logic [VW-1:0] f, input logic [3:0] v,
                             input logic [3:0] e, input logic outRdy, input logic clr);
        parser_rec_t r;
        bit          popNow;
        bit          fullNow;
        popNow  = (modelQ.size() > 0) && outRdy;
        fullNow = (modelQ.size() == DEPTH);
        if (popNow) begin
            r = modelQ.pop_front();
        end
        if (clr) begin
            modelOvf   = 1'b0;
            modelDrops = 0;
        end
        if (inRdy) begin
            if (!fullNow || popNow) begin
                r.seq   = modelSeq;
                r.error = e;
                r.valid = v;
                r.field = f;
                modelQ.push_back(r);
            end else begin
                modelOvf = 1'b1;
                if (modelDrops < (2 ** DROP_W) - 1) modelDrops++;
            end
            modelSeq = modelSeq + 8'd1;
        end
    endtask

    task automatic checkOutput(input string tag);
        parser_rec_t expRec;
        logic        expValid;
        logic        expGood;
        parser_rec_t actRec;
        expValid = (modelQ.size() != 0);
        expRec   = expValid ? modelQ[0] : '0;
        expGood  = expValid && (&expRec.valid) && !(|expRec.error);
        actRec   = {bus.OutRec_Seq, bus.OutRec_Error, bus.OutRec_FieldValid, bus.OutRec_Field};
        check({tag, " valid"}, 256'(bus.OutRec_Valid), 256'(expValid));
        check({tag, " fill"}, 256'(Fill), 256'(modelQ.size()));
        check({tag, " overflow"}, 256'(Overflow), 256'(modelOvf));
        check({tag, " dropcnt"}, 256'(DropCnt), 256'(modelDrops));
        check({tag, " record"}, 256'(actRec), 256'(expRec));
        check({tag, " good"}, 256'(bus.OutRec_Good), 256'(expGood));
    endtask

    task automatic applyStimulus(input logic inRdy, input logic [VW-1:0] f, input logic [3:0] v,
                                 input logic [3:0] e, input logic outRdy, input logic clr,
                                 input string tag);
        bus.InRes_Ready  = inRdy;
        bus.InRes_Field  = f;
        bus.InRes_Valid  = v;
        bus.InRes_Error  = e;
        bus.OutRec_Ready = outRdy;
        Clr              = clr;
        @(posedge Clk);
        modelStep(inRdy, f, v, e, outRdy, clr);
        #1;
        checkOutput(tag);
    endtask

    function automatic logic [VW-1:0] randField();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reset is asserted between edges so its asynchronous effect is observed directly.
    task automatic doReset();
        #2;
        Rst_n            = 1'b0;
        bus.InRes_Ready  = 1'b0;
        bus.InRes_Field  = '0;
        bus.InRes_Valid  = '0;
        bus.InRes_Error  = '0;
        bus.OutRec_Ready = 1'b0;
        Clr              = 1'b0;
        #1;
        check("reset ctrl", 256'({bus.OutRec_Valid, bus.OutRec_Good, Fill, Overflow, DropCnt}), 256'(0));
        check("reset data", 256'({bus.OutRec_Seq, bus.OutRec_Error, bus.OutRec_FieldValid,
                                  bus.OutRec_Field}), 256'(0));
        modelQ.delete();
        modelSeq   = 8'd0;
        modelDrops = 0;
        modelOvf   = 1'b0;
        #10;
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [VW-1:0] f1, f2, f3;
        logic [7:0]    lastSeq;
        checks = 0;
        passes = 0;
        f1 = {16{8'h11}};
        f2 = {16{8'h22}};
        f3 = {16{8'h33}};
        vecs[0] = '{1'b1, f1, 1'b1, 1'b1, 8'd0, f1, 4'd1};
        vecs[1] = '{1'b1, f2, 1'b1, 1'b1, 8'd1, f2, 4'd1};
        vecs[2] = '{1'b1, f3, 1'b1, 1'b1, 8'd2, f3, 4'd1};
        vecs[3] = '{1'b0, '0, 1'b1, 1'b0, 8'd0, '0, 4'd0};

        #1;
        doReset();

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].inRdy, vecs[i].field, 4'hF, 4'h0, vecs[i].outRdy, 1'b0, "table");
            check("table valid", 256'(bus.OutRec_Valid), 256'(vecs[i].expValid));
            check("table seq", 256'(bus.OutRec_Seq), 256'(vecs[i].expSeq));
            check("table field", 256'(bus.OutRec_Field), 256'(vecs[i].expField));
            check("table good", 256'(bus.OutRec_Good), 256'(vecs[i].expValid));
            check("table fill", 256'(Fill), 256'(vecs[i].expFill));
        end

        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, randField(), 4'hF, 4'h0, 1'b0, 1'b0, "overfill");
        end
        check("overfill fill", 256'(Fill), 256'(8));
        check("overfill flag", 256'(Overflow), 256'(1));
        check("overfill drops", 256'(DropCnt), 256'(2));
        for (int i = 0; i < 8; i++) begin
            check("drain seq", 256'(bus.OutRec_Seq), 256'(i));
            applyStimulus(1'b0, '0, 4'h0, 4'h0, 1'b1, 1'b0, "drain");
        end
        check("drain empty", 256'({bus.OutRec_Valid, Fill}), 256'(0));

        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, randField(), 4'hF, 4'h0, 1'b0, 1'b0, "fill8");
        end
        applyStimulus(1'b1, randField(), 4'hF, 4'h0, 1'b1, 1'b0, "full pushpop");
        check("pushpop fill", 256'(Fill), 256'(8));
        check("pushpop nodrop", 256'({Overflow, DropCnt}), 256'(0));
        lastSeq = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            lastSeq = bus.OutRec_Seq;
            applyStimulus(1'b0, '0, 4'h0, 4'h0, 1'b1, 1'b0, "drain2");
        end
        check("pushpop last seq", 256'(lastSeq), 256'(8));

        applyStimulus(1'b1, randField(), 4'b0111, 4'b1000, 1'b0, 1'b0, "partial");
        check("partial good", 256'(bus.OutRec_Good), 256'(0));
        check("partial fv", 256'(bus.OutRec_FieldValid), 256'(4'b0111));
        check("partial err", 256'(bus.OutRec_Error), 256'(4'b1000));
        applyStimulus(1'b0, '0, 4'h0, 4'h0, 1'b1, 1'b0, "partial pop");

        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, randField(), 4'hF, 4'h0, 1'b0, 1'b0, "predrop");
        end
        check("predrop drops", 256'(DropCnt), 256'(3));
        applyStimulus(1'b1, randField(), 4'hF, 4'h0, 1'b0, 1'b1, "clr+drop");
        check("clrdrop flag", 256'(Overflow), 256'(1));
        check("clrdrop drops", 256'(DropCnt), 256'(1));
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, randField(), 4'hF, 4'h0, 1'b0, 1'b0, "saturate");
        end
        check("sat drops", 256'(DropCnt), 256'(15));
        applyStimulus(1'b0, '0, 4'h0, 4'h0, 1'b0, 1'b1, "clr only");
        check("clr only", 256'({Overflow, DropCnt, Fill}), 256'({1'b0, 4'd0, 4'd8}));

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 4'h0, 4'h0, 1'b1, 1'b0, "to five");
        end
        check("mid fill", 256'(Fill), 256'(5));
        doReset();
        applyStimulus(1'b1, f2, 4'hF, 4'h0, 1'b0, 1'b0, "post reset");
        check("post reset seq", 256'({bus.OutRec_Valid, bus.OutRec_Seq}), 256'({1'b1, 8'd0}));

        for (int i = 0; i < 400; i++) begin
            logic outRdy;
            outRdy = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            applyStimulus(1'($urandom_range(0, 1)), randField(), 4'($urandom), 4'($urandom),
                          outRdy, 1'($urandom_range(0, 15) == 0), "random");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/parser_result_fifo.md
Name: parser_result_fifo

Overview:
- Downstream stage of packet_parser_top. Captures each per-packet result on the OutBus_AllValues_Ready pulse: the field vector, the per-field valid bits and the per-field error bits.
- Tags every result with a packet sequence number and buffers it in a FIFO of DEPTH records.
- Presents records to the consumer (match/lookup stage) over a valid/ready handshake.
- Counts results dropped on overflow, so a stalled consumer never back-pressures the parser, which has no ready input.

Parameters:
- FIELD_NUMBER, 4, number of parsed fields per packet.
- FIELD_SIZE_MAX, 4, bytes per field slot.
- DEPTH, 8, record capacity. Must be a power of 2, at least 2.
- SEQ_W, 8, sequence-number width.
- DROP_W, 16, drop-counter width.

Ports:
- Clk  in  1  clock.
- Rst_n  in  1  asynchronous reset, active-low.
- InRes_Ready  in  1  single-cycle pulse, one per parsed packet. Driven from OutBus_AllValues_Ready.
- InRes_Field  in  FIELD_NUMBER*FIELD_SIZE_MAX*8  field vector; field k occupies bits [k*FIELD_SIZE_MAX*8 +: FIELD_SIZE_MAX*8].
- InRes_Valid  in  FIELD_NUMBER  per-field valid bits.
- InRes_Error  in  FIELD_NUMBER  per-field offset/size error bits.
- Clr  in  1  synchronous clear of Overflow and DropCnt.
- OutRec_Valid  out  1  a record is presented.
- OutRec_Ready  in  1  consumer accepts the record.
- OutRec_Field  out  FIELD_NUMBER*FIELD_SIZE_MAX*8  buffered field vector.
- OutRec_FieldValid  out  FIELD_NUMBER  buffered valid bits.
- OutRec_Error  out  FIELD_NUMBER  buffered error bits.
- OutRec_Good  out  1  high when all FieldValid bits are 1 and all Error bits are 0.
- OutRec_Seq  out  SEQ_W  sequence number of the presented record.
- Fill  out  $clog2(DEPTH)+1  records held, 0..DEPTH, including the presented one.
- Overflow  out  1  sticky: at least one result has been dropped.
- DropCnt  out  DROP_W  count of dropped results, saturating.

Behaviour:
- Reset (Rst_n low, asynchronous):
  - all pointers 0, Fill=0, Overflow=0, DropCnt=0, sequence counter=0.
  - OutRec_Valid=0, OutRec_Good=0; all OutRec data outputs 0.
  - Reset mid-operation discards all held records. No partial record survives reset.
- Sequence counter:
  - Increments on every InRes_Ready pulse, whether the result is accepted or dropped. Wraps modulo 2^SEQ_W.
  - The stored tag is the counter value before the increment, so the first result after reset carries Seq=0 and drops show up as gaps in Seq.
- Push: occurs when InRes_Ready=1 and the FIFO is either not full, or full with a pop in the same cycle. The record is {Seq, Error, Valid, Field}, sampled on that edge.
- Drop: occurs when InRes_Ready=1, Fill==DEPTH and there is no pop that cycle.
  - Overflow is set to 1.
  - DropCnt increments by 1, saturating at all-ones.
  - Fill, pointers and OutRec outputs are unchanged.
- Pop: occurs when OutRec_Valid=1 and OutRec_Ready=1 at a rising edge.
  - OutRec_Ready is ignored while OutRec_Valid=0.
  - OutRec outputs are registered and stay stable while OutRec_Valid=1 and OutRec_Ready=0.
- Latency:
  - Push into an empty FIFO at edge N gives OutRec_Valid=1 with that record after edge N (one cycle), registered, first-word-fall-through.
  - After a pop at edge N, the next record (if any) is presented from edge N. There are no bubbles, so back-to-back pops sustain one record per cycle.
- Fill changes per cycle:
  - +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Simultaneous push and pop at Fill==1: the new record is presented from that edge.
- Clr: sets Overflow=0 and DropCnt=0. If a drop occurs in the same cycle, the result is Overflow=1 and DropCnt=1. Clr does not affect stored records or Seq.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from Fill.

Decomposition:
- parser_pkg holds:
  - FIELD_NUMBER and FIELD_SIZE_MAX defaults;
  - localparam FIELD_VEC_W = FIELD_NUMBER*FIELD_SIZE_MAX*8;
  - localparam REC_W = SEQ_W + 2*FIELD_NUMBER + FIELD_VEC_W;
  - the record typedef {seq, error, valid, field}, shared with the parser and downstream consumers.
- One sub-module, sat_counter (width parameter, inc, clr, saturating), instantiated for DropCnt.
- Storage is a register array inside this block.

Test Plan:
- Reset, then 3 results with Field=128'h11..,22..,33.., Valid=4'hF, Error=0, with OutRec_Ready=1 throughout:
  - each record appears one cycle after its pulse;
  - Seq is 0,1,2; Good=1; Fill returns to 0.
- Hold OutRec_Ready=0 and push 10 results (DEPTH=8):
  - Fill=8, Overflow=1, DropCnt=2;
  - after draining, Seq reads 0..7 and Seq 8 and 9 are absent.
- Fill=8 with a push and a pop on the same edge: no drop, Fill stays 8, and the last record popped carries the new Seq.
- Push a result with Valid=4'b0111 and Error=4'b1000: OutRec_Good=0 and the bits are reproduced exactly.
- Assert Clr together with a drop: Overflow=1 and DropCnt=1. Force DropCnt to saturation (DROP_W=4, 20 drops): DropCnt holds 15.
- Assert Rst_n low with Fill=5 mid-stream: all outputs 0 immediately; the next push is tagged Seq=0.
